// File: rtl/decoder_3to8.sv
// Registered 3-to-8 one-hot decoder with 1-cycle latency and async active-low reset.
// Optional build macro DECODER_3TO8_HOLD_EN: Y holds its last value when E=0 instead of idling.
`timescale 1ns/1ps
module decoder_3to8 #(
    parameter bit OUT_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] A,
    input  logic       E,
    output logic [7:0] Y,
    output logic       Y_valid
);

    // Decode is kept active-high internally; polarity is applied only at the output,
    // so reset and idle both map to the correct idle pattern for either polarity.
    logic [7:0] y_q, y_d;
    logic       valid_q, valid_d;

    always_comb begin
`ifdef DECODER_3TO8_HOLD_EN
        y_d = y_q;
`else
        y_d = '0;
`endif
        valid_d = E;
        if (E) begin
            unique case (A)
                3'd0:    y_d = 8'h01;
                3'd1:    y_d = 8'h02;
                3'd2:    y_d = 8'h04;
                3'd3:    y_d = 8'h08;
                3'd4:    y_d = 8'h10;
                3'd5:    y_d = 8'h20;
                3'd6:    y_d = 8'h40;
                default: y_d = 8'h80;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign Y       = OUT_ACTIVE_LOW ? ~y_q : y_q;
    assign Y_valid = valid_q;

endmodule

// File: tb/tb_decoder_3to8.sv
// Scoreboard bench for decoder_3to8: drives both output polarities from shared stimulus.
`timescale 1ns/1ps
module tb_decoder_3to8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] A;
    logic       E;
    logic [7:0] y_hi, y_lo;
    logic       v_hi, v_lo;

    decoder_3to8 #(.OUT_ACTIVE_LOW(1'b0)) u_hi (
        .clk(clk), .rst_n(rst_n), .A(A), .E(E), .Y(y_hi), .Y_valid(v_hi)
    );
    decoder_3to8 #(.OUT_ACTIVE_LOW(1'b1)) u_lo (
        .clk(clk), .rst_n(rst_n), .A(A), .E(E), .Y(y_lo), .Y_valid(v_lo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] y;
        logic       v;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    logic [7:0] onehot_tbl [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    logic [7:0] m_y = 8'h00;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    endtask

    // Drive one cycle at the falling edge; push what the DUT must show after the next rising edge.
    task automatic cycle(input logic [2:0] a, input logic e, input logic r);
        logic [7:0] nxt;
        @(negedge clk);
        A     = a;
        E     = e;
        rst_n = r;
        if (!r) begin
            m_y = 8'h00;
        end else begin
`ifdef DECODER_3TO8_HOLD_EN
            nxt = e ? onehot_tbl[a] : m_y;
`else
            nxt = e ? onehot_tbl[a] : 8'h00;
`endif
            m_y = nxt;
            q.push_back('{y: nxt, v: e});
        end
    endtask

    always @(posedge clk) begin
        exp_t ex;
        #2;
        if (!rst_n) begin
            check("rst_y_hi", y_hi, 8'h00);
            check("rst_y_lo", y_lo, 8'hFF);
            check("rst_v_hi", {7'd0, v_hi}, 8'h00);
            check("rst_v_lo", {7'd0, v_lo}, 8'h00);
        end else if (q.size() > 0) begin
            ex = q.pop_front();
            check("y_hi", y_hi, ex.y);
            check("y_lo", y_lo, ~ex.y);
            check("valid_hi", {7'd0, v_hi}, {7'd0, ex.v});
            check("valid_lo", {7'd0, v_lo}, {7'd0, ex.v});
            check("onehot", {7'd0, ($countones(y_hi) > 1)}, 8'h00);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        A     = 3'd0;
        E     = 1'b0;
        #1;
        check("por_y_hi", y_hi, 8'h00);
        check("por_y_lo", y_lo, 8'hFF);
        check("por_valid", {7'd0, v_hi}, 8'h00);
        cycle(3'd0, 1'b0, 1'b0);
        cycle(3'd0, 1'b0, 1'b0);

        // Sweep 0..7 back to back; first decode at the first edge after release.
        for (int i = 0; i < 8; i++) cycle(i[2:0], 1'b1, 1'b1);

        // Disable after A=5.
        cycle(3'd5, 1'b1, 1'b1);
        cycle(3'd2, 1'b0, 1'b1);
        cycle(3'd7, 1'b0, 1'b1);
        cycle(3'd2, 1'b1, 1'b1);
        cycle(3'd6, 1'b0, 1'b1);

        // Async reset between edges after A=3.
        cycle(3'd3, 1'b1, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        m_y   = 8'h00;
        #1;
        check("async_y_hi", y_hi, 8'h00);
        check("async_y_lo", y_lo, 8'hFF);
        check("async_valid", {7'd0, v_hi}, 8'h00);
        cycle(3'd3, 1'b1, 1'b0);
        cycle(3'd3, 1'b1, 1'b1);
        cycle(3'd3, 1'b0, 1'b1);

        // Random A/E/rst_n, reset asserted in roughly 1 of 16 cycles.
        for (int i = 0; i < 1000; i++)
            cycle(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), ($urandom_range(0, 15) != 0));

        cycle(3'd0, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d entries left, expected 0", q.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/decoder_3to8.md
DECODER_3TO8 -- requirements
Module: decoder_3to8

Interface
REQ-001 Parameter OUT_ACTIVE_LOW, default 0: 0 = asserted output bit is 1 with idle 0x00; 1 = asserted output bit is 0 with idle 0xFF.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 A  input  3  select code; A[2] is MSB.
REQ-005 E  input  1  enable, active-high.
REQ-006 Y  output  8  registered one-hot decode; bit Y[A] is the asserted bit.
REQ-007 Y_valid  output  1  registered copy of E, aligned with Y.

Function
REQ-008 The block SHALL sample A and E on each rising clk edge and present the result on Y and Y_valid one cycle later; latency is exactly 1 cycle and there is no combinational path from input to output.
REQ-009 With E=1 at the sample edge, Y SHALL have exactly one asserted bit, at index A (A=0 gives 0x01, A=7 gives 0x80 when OUT_ACTIVE_LOW=0), and all other bits idle.
REQ-010 With E=0 at the sample edge, Y SHALL be the idle pattern (0x00, or 0xFF when OUT_ACTIVE_LOW=1), unless DECODER_3TO8_HOLD_EN is defined (REQ-017).
REQ-011 Y_valid SHALL equal E as sampled at the previous edge.
REQ-012 When OUT_ACTIVE_LOW=1, Y SHALL be the bitwise inverse of the OUT_ACTIVE_LOW=0 result for the same inputs, in every case including reset.
REQ-013 Back-to-back changes of A on consecutive cycles SHALL each appear on Y in order, one cycle apart, with no glitch cycles and no dropped codes.
REQ-014 Y SHALL never have more than one asserted bit in any cycle.
REQ-015 X or Z on A while E=0 SHALL NOT disturb Y.

Reset
REQ-016 While rst_n=0, Y SHALL be the idle pattern and Y_valid SHALL be 0, taking effect immediately and independent of clk. Reset asserted mid-operation SHALL override any pending decode. The first decode SHALL occur at the first rising edge after rst_n deasserts.

Configuration
REQ-017 Macro DECODER_3TO8_HOLD_EN.
- Defined: when E=0 at a sample edge, Y SHALL hold its previous value and Y_valid SHALL go 0. Reset still forces the idle pattern.
- Undefined: REQ-010 applies, so E=0 forces the idle pattern.
- Y_valid behaviour is identical in both builds.

Verification
REQ-018 Sweep: reset, then E=1 with A stepping 0 to 7 one per cycle. Y SHALL be 0x01, 0x02, 0x04, 0x08, 0x10, 0x20, 0x40, 0x80, each one cycle after its A, with Y_valid=1.
REQ-019 Disable: E=1 and A=5 (Y=0x20), then E=0. Y SHALL be 0x00 next cycle with Y_valid=0; with HOLD_EN defined, Y SHALL stay 0x20 with Y_valid=0.
REQ-020 Async reset: E=1 and A=3 (Y=0x08), then drop rst_n between edges. Y SHALL be 0x00 and Y_valid=0 without waiting for a clock edge; after release, A=3 SHALL give Y=0x08 one edge later.
REQ-021 Active-low build: OUT_ACTIVE_LOW=1. Reset SHALL give Y=0xFF; E=1 with A=2 SHALL give Y=0xFB; E=0 SHALL give Y=0xFF.
REQ-022 Random: 1000 random A/E/rst_n cycles checked against a 1-cycle-delayed reference model. Every cycle SHALL show Y onehot or idle and Y_valid matching E delayed one cycle.
